// File: rtl/lut_init_seq.sv
// Copies lookup-table entries 0..LAST_PTR into data memory at BASE_ADR+ptr,
// one acknowledged write per entry; restartable and abortable.
module lut_init_seq #(
   parameter int unsigned   LAST_PTR = 5,
   parameter logic [7:0]    BASE_ADR = 8'd0,
   localparam int unsigned  PTR_W    = 5,
   localparam int unsigned  DAT_W    = 8,
   localparam int unsigned  ADR_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [PTR_W-1:0]  ptr_o,
   input  logic [DAT_W-1:0]  lut_dat_i,
   output logic              dm_wen_o,
   output logic [ADR_W-1:0]  dm_adr_o,
   output logic [DAT_W-1:0]  dm_dat_o,
   input  logic              dm_ack_i,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
   logic [DAT_W-1:0]    r_data, w_data_nxt;
   logic                w_run_nxt, w_wr_nxt;

   logic [PTR_W-1:0]    r_ptr_o;
   logic                r_wen;
   logic [ADR_W-1:0]    r_adr;
   logic [DAT_W-1:0]    r_dat;
   logic                r_busy;
   logic                r_done;

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_data_nxt  = r_data;
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_ptr_nxt   = '0;
               w_state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            if (abort_i) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_data_nxt  = lut_dat_i;
               w_state_nxt = ST_WR;
            end
         end
         ST_WR: begin
            // An ack on the abort edge still completes that write at the memory
            if (abort_i) begin
               w_state_nxt = ST_IDLE;
            end else if (dm_ack_i) begin
               if (r_ptr == PTR_W'(LAST_PTR)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_ptr_nxt   = r_ptr + PTR_W'(1);
                  w_state_nxt = ST_RD;
               end
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      w_run_nxt = (w_state_nxt == ST_RD) || (w_state_nxt == ST_WR);
      w_wr_nxt  = (w_state_nxt == ST_WR);
   end

   // State and output registers; outputs are decoded from next state so they
   // line up with the state they describe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_data  <= '0;
         r_ptr_o <= '0;
         r_wen   <= 1'b0;
         r_adr   <= '0;
         r_dat   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_data  <= w_data_nxt;
         r_ptr_o <= w_run_nxt ? w_ptr_nxt : '0;
         r_wen   <= w_wr_nxt;
         r_adr   <= w_wr_nxt ? ADR_W'(BASE_ADR + ADR_W'(w_ptr_nxt)) : '0;
         r_dat   <= w_wr_nxt ? w_data_nxt : '0;
         r_busy  <= w_run_nxt;
         r_done  <= (w_state_nxt == ST_DONE);
      end
   end

   assign ptr_o    = r_ptr_o;
   assign dm_wen_o = r_wen;
   assign dm_adr_o = r_adr;
   assign dm_dat_o = r_dat;
   assign busy_o   = r_busy;
   assign done_o   = r_done;

endmodule

// File: tb/tb_lut_init_seq.sv
// Directed bench for lut_init_seq: default, wrapped-base and single-entry
// instances share stimulus; expected outputs come from a per-cycle vector table.
module tb_lut_init_seq;

   localparam int ST_I  = 0;
   localparam int ST_RD = 1;
   localparam int ST_WR = 2;
   localparam int ST_DN = 3;

   typedef struct {
      logic       start;
      logic       abort;
      logic       ack;
      int         st;
      logic [4:0] ptr;
   } row_t;

   row_t tbl[$];

   logic clk, rst_n, start_i, abort_i, dm_ack_i;

   logic [4:0] ptr_a, ptr_b, ptr_c;
   logic [7:0] lut_a, lut_b, lut_c;
   logic       wen_a, wen_b, wen_c;
   logic [7:0] adr_a, adr_b, adr_c;
   logic [7:0] dat_a, dat_b, dat_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [7:0] lut_f(input logic [4:0] p);
      case (p)
         5'd0:    return 8'hF5;
         5'd1:    return 8'h09;
         5'd2:    return 8'hEC;
         5'd3:    return 8'h0E;
         5'd4:    return 8'h03;
         5'd5:    return 8'h11;
         default: return 8'h00;
      endcase
   endfunction

   assign lut_a = lut_f(ptr_a);
   assign lut_b = lut_f(ptr_b);
   assign lut_c = lut_f(ptr_c);

   lut_init_seq u_a (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .ptr_o(ptr_a), .lut_dat_i(lut_a), .dm_wen_o(wen_a), .dm_adr_o(adr_a),
      .dm_dat_o(dat_a), .dm_ack_i(dm_ack_i), .busy_o(busy_a), .done_o(done_a));

   lut_init_seq #(.LAST_PTR(5), .BASE_ADR(8'hFE)) u_b (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .ptr_o(ptr_b), .lut_dat_i(lut_b), .dm_wen_o(wen_b), .dm_adr_o(adr_b),
      .dm_dat_o(dat_b), .dm_ack_i(dm_ack_i), .busy_o(busy_b), .done_o(done_b));

   lut_init_seq #(.LAST_PTR(0), .BASE_ADR(8'h00)) u_c (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .ptr_o(ptr_c), .lut_dat_i(lut_c), .dm_wen_o(wen_c), .dm_adr_o(adr_c),
      .dm_dat_o(dat_c), .dm_ack_i(dm_ack_i), .busy_o(busy_c), .done_o(done_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic s, input logic a, input logic k,
                               input int st, input int p);
      row_t r;
      r.start = s; r.abort = a; r.ack = k; r.st = st; r.ptr = 5'(p);
      tbl.push_back(r);
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, ".a.ptr"},  32'(ptr_a),  0);
      chk({tag, ".a.wen"},  32'(wen_a),  0);
      chk({tag, ".a.adr"},  32'(adr_a),  0);
      chk({tag, ".a.dat"},  32'(dat_a),  0);
      chk({tag, ".a.busy"}, 32'(busy_a), 0);
      chk({tag, ".a.done"}, 32'(done_a), 0);
      chk({tag, ".b.wen"},  32'(wen_b),  0);
      chk({tag, ".b.adr"},  32'(adr_b),  0);
      chk({tag, ".c.wen"},  32'(wen_c),  0);
      chk({tag, ".c.busy"}, 32'(busy_c), 0);
   endtask

   task automatic chk_row(input int idx, input row_t r);
      string      t;
      logic       wr, run;
      logic [7:0] adr_fe;
      wr     = (r.st == ST_WR);
      run    = (r.st == ST_RD) || (r.st == ST_WR);
      adr_fe = 8'hFE + 8'(r.ptr);
      t = $sformatf("row%0d", idx);
      chk({t, ".a.ptr"},  32'(ptr_a),  run ? 32'(r.ptr) : 0);
      chk({t, ".a.wen"},  32'(wen_a),  32'(wr));
      chk({t, ".a.adr"},  32'(adr_a),  wr ? 32'(r.ptr) : 0);
      chk({t, ".a.dat"},  32'(dat_a),  wr ? 32'(lut_f(r.ptr)) : 0);
      chk({t, ".a.busy"}, 32'(busy_a), 32'(run));
      chk({t, ".a.done"}, 32'(done_a), 32'(r.st == ST_DN));
      chk({t, ".b.wen"},  32'(wen_b),  32'(wr));
      chk({t, ".b.adr"},  32'(adr_b),  wr ? 32'(adr_fe) : 0);
      chk({t, ".b.dat"},  32'(dat_b),  wr ? 32'(lut_f(r.ptr)) : 0);
   endtask

   initial begin
      // nominal run with a stray abort in IDLE
      add(1,0,1,ST_I,0);
      for (int p = 0; p <= 5; p++) begin add(0,0,1,ST_RD,p); add(0,0,1,ST_WR,p); end
      add(0,0,1,ST_DN,0); add(0,1,1,ST_I,0);
      // ack stalled 3 cycles on entry 2, abort ignored in DONE
      add(1,0,1,ST_I,0);
      add(0,0,1,ST_RD,0); add(0,0,1,ST_WR,0); add(0,0,1,ST_RD,1); add(0,0,1,ST_WR,1);
      add(0,0,1,ST_RD,2);
      add(0,0,0,ST_WR,2); add(0,0,0,ST_WR,2); add(0,0,0,ST_WR,2); add(0,0,1,ST_WR,2);
      for (int p = 3; p <= 5; p++) begin add(0,0,1,ST_RD,p); add(0,0,1,ST_WR,p); end
      add(0,1,1,ST_DN,0); add(0,0,1,ST_I,0);
      // abort in WR of entry 3 without ack, restart, abort in RD
      add(1,0,1,ST_I,0);
      for (int p = 0; p <= 2; p++) begin add(0,0,1,ST_RD,p); add(0,0,1,ST_WR,p); end
      add(0,0,1,ST_RD,3); add(0,1,0,ST_WR,3); add(0,0,1,ST_I,0);
      add(1,0,1,ST_I,0); add(0,0,1,ST_RD,0); add(0,0,1,ST_WR,0); add(0,1,1,ST_RD,1);
      add(0,0,1,ST_I,0);
      // abort together with ack in WR
      add(1,0,1,ST_I,0); add(0,0,1,ST_RD,0); add(0,1,1,ST_WR,0); add(0,0,1,ST_I,0);
      // start held high: back-to-back runs with one IDLE cycle between
      add(1,0,1,ST_I,0);
      for (int p = 0; p <= 5; p++) begin add(1,0,1,ST_RD,p); add(1,0,1,ST_WR,p); end
      add(1,0,1,ST_DN,0); add(1,0,1,ST_I,0);
      for (int p = 0; p <= 5; p++) begin add(0,0,1,ST_RD,p); add(0,0,1,ST_WR,p); end
      add(0,0,1,ST_DN,0); add(0,0,1,ST_I,0);

      rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; dm_ack_i = 1'b1;
      #3 chk_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      // LAST_PTR=0 instance: write in E+2, done in E+3
      @(negedge clk);
      chk("idle.a.busy", 32'(busy_a), 0);
      start_i = 1'b1;
      @(negedge clk); start_i = 1'b0;
      chk("c.rd.busy", 32'(busy_c), 1);
      chk("c.rd.ptr",  32'(ptr_c),  0);
      chk("c.rd.wen",  32'(wen_c),  0);
      @(negedge clk);
      chk("c.wr.wen", 32'(wen_c), 1);
      chk("c.wr.adr", 32'(adr_c), 0);
      chk("c.wr.dat", 32'(dat_c), 32'h0F5);
      @(negedge clk);
      chk("c.dn.done", 32'(done_c), 1);
      chk("c.dn.wen",  32'(wen_c),  0);
      chk("c.dn.busy", 32'(busy_c), 0);
      @(negedge clk);
      chk("c.idle.done", 32'(done_c), 0);
      repeat (10) @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         chk_row(i, tbl[i]);
         start_i  = tbl[i].start;
         abort_i  = tbl[i].abort;
         dm_ack_i = tbl[i].ack;
      end

      // reset asserted during a WR stall drops outputs without a clock edge
      @(negedge clk); start_i = 1'b1; abort_i = 1'b0; dm_ack_i = 1'b0;
      @(negedge clk); start_i = 1'b0;
      @(negedge clk);
      chk("stall.a.wen", 32'(wen_a), 1);
      chk("stall.a.adr", 32'(adr_a), 0);
      #2 rst_n = 1'b0;
      #1 chk_zero("async");
      @(negedge clk); rst_n = 1'b1; dm_ack_i = 1'b1;
      @(negedge clk);
      chk("post.a.ptr",  32'(ptr_a),  0);
      chk("post.a.busy", 32'(busy_a), 0);
      chk("post.a.wen",  32'(wen_a),  0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lut_init_seq.md
# lut_init_seq

Sequencer that walks the data-memory lookup table (`lut_i`) from pointer 0 through `LAST_PTR` and copies each table entry into data memory at `BASE_ADR + ptr`, one write per entry, with a write-acknowledge handshake toward the memory. It sits between the lookup table and the data-memory write port. It is used to preload constant operands before the core runs, and can be re-triggered or aborted by the test/control logic.

## Interface

Parameters:
- `LAST_PTR`, default 5: last table pointer copied; legal range 0..31.
- `BASE_ADR`, default 8'd0: data-memory address that receives entry 0.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  begin a copy run; sampled only in IDLE.
- `abort_i`  in  1  terminate a run; sampled in RD and WR.
- `ptr_o`  out  5  pointer to `lut_i.ptr_i`.
- `lut_dat_i`  in  8  `lut_i.dm_i`, combinational from `ptr_o`.
- `dm_wen_o`  out  1  data-memory write request.
- `dm_adr_o`  out  8  write address.
- `dm_dat_o`  out  8  write data.
- `dm_ack_i`  in  1  memory accepts the write on any edge where `dm_wen_o && dm_ack_i`.
- `busy_o`  out  1  high in RD and WR.
- `done_o`  out  1  one-cycle pulse when a run completes normally.

## Operation

- State register: IDLE, RD, WR, DONE. Internal registers: `ptr_q` (5 bits) and `data_q` (8 bits).
- IDLE:
  - `busy_o`=0, `dm_wen_o`=0, `ptr_o`=0.
  - If `start_i`=1: `ptr_q`<=0, go to RD.
- RD:
  - `ptr_o`=`ptr_q`.
  - At the edge: `data_q`<=`lut_dat_i`, go to WR.
  - If `abort_i`=1: go to IDLE; `data_q` is don't-care.
- WR:
  - `dm_wen_o`=1, `dm_adr_o`=`BASE_ADR + ptr_q` (8-bit sum, wraps modulo 256), `dm_dat_o`=`data_q`, `ptr_o`=`ptr_q`.
  - `dm_wen_o`, `dm_adr_o` and `dm_dat_o` are held stable until `dm_ack_i`=1.
  - On ack: if `ptr_q`==`LAST_PTR` go to DONE; else `ptr_q`<=`ptr_q`+1 and go to RD.
  - Without ack: stay in WR.
- DONE: `done_o`=1 for exactly one cycle, then go to IDLE.
- `abort_i` in WR:
  - Go to IDLE next cycle; no `done_o`.
  - If `dm_ack_i`=1 on the same edge, that write counts as completed to the memory, but the run still aborts.
- `abort_i` is ignored in IDLE and DONE. `start_i` is ignored outside IDLE; a `start_i` held high in DONE takes effect in the following IDLE cycle.
- `dm_adr_o` and `dm_dat_o` outside WR: drive 0.

## Timing

- Reset (asynchronous assert, `rst_n`=0): state=IDLE, `ptr_q`=0, `data_q`=0. All outputs 0: `ptr_o`, `dm_wen_o`, `dm_adr_o`, `dm_dat_o`, `busy_o`, `done_o`. Reset deassertion is synchronous to `clk` by the system.
- Reset mid-run: the run is dropped immediately and `dm_wen_o` falls asynchronously. There is no partial-write recovery.
- `start_i` sampled at edge E: RD during cycle E+1, WR during cycle E+2.
- Cost per entry: 2 cycles minimum (RD + WR with immediate ack); each cycle of ack stall adds one cycle.
- Full run, `LAST_PTR`=5, ack always high:
  - Writes occur in cycles E+2, E+4, …, E+12.
  - `done_o` is high in cycle E+13.
  - IDLE in cycle E+14, where a new `start_i` can be accepted.
- `LAST_PTR`=0: one write in cycle E+2, `done_o` in cycle E+3.
- `ptr_o` changes only on clock edges. `lut_dat_i` settles combinationally within the RD cycle.

## Test plan

- Default parameters, `dm_ack_i` tied 1, `start_i` pulse: writes (adr,dat) = (0,F5), (1,09), (2,EC), (3,0E), (4,03), (5,11) in consecutive WR cycles; `done_o` a single pulse 13 cycles after start; `busy_o` high for 12 cycles.
- `BASE_ADR`=8'hFE: addresses FE, FF, 00, 01, 02, 03 (wrap); data as in the default scenario.
- `dm_ack_i` low for 3 cycles on entry 2: `dm_wen_o`, `dm_adr_o`=2 and `dm_dat_o`=EC are held for 4 cycles; total run extends by 3 cycles; data order unchanged.
- `abort_i` pulsed in the WR of entry 3 with `dm_ack_i`=0: no write of entry 3 accepted, IDLE next cycle, no `done_o`. A new start then restarts from entry 0.
- `start_i` held high continuously: back-to-back runs with exactly one IDLE cycle between the `done_o` pulse and the next RD. Extra `start_i` pulses mid-run have no effect.
- `rst_n` asserted during a WR stall: all outputs go to 0 without waiting for `clk`; after release the block is in IDLE with `ptr_o`=0.
